// File: rtl/commit_queue.sv
// In-order retirement queue between execute and the regfile, data FIFO and CSR block.
// The head entry retires directly, or through a short AXI-Lite write sequence for CSR entries.
module commit_queue #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 4,
  parameter int CSR_EXC_NUM = 2,
  parameter int CNT_W       = 64
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              execute_valid,
  output logic              execute_ready,
  input  logic [4:0]        execute_rd,
  input  logic [XLEN-1:0]   execute_rd_val,
  input  logic [XLEN-1:0]   execute_inst_pc,
  input  logic [XLEN-1:0]   execute_jump_pc,
  input  logic              execute_jump_valid,
  input  logic [5:0]        execute_exception_num,
  input  logic [XLEN-1:0]   execute_exception_val,
  input  logic              execute_exception_valid,
  input  logic [XLEN-1:0]   execute_store_addr,
  input  logic [XLEN-1:0]   execute_store_val,
  input  logic [1:0]        execute_store_size,
  input  logic              execute_store_valid,
  input  logic [11:0]       execute_csr_write_addr,
  input  logic [XLEN-1:0]   execute_csr_write_val,
  input  logic              execute_csr_write_valid,

  input  logic              datafifo_full,
  output logic [XLEN-1:0]   datafifo_addr_out,
  output logic [XLEN-1:0]   datafifo_val_out,
  output logic [1:0]        datafifo_size_out,
  output logic              datafifo_valid_out,

  output logic [5:0]        exception_num_out,
  output logic [XLEN-1:0]   exception_val_out,
  output logic [XLEN-1:0]   exception_pc_out,
  output logic              exception_valid_out,

  output logic [4:0]        rd_out,
  output logic [XLEN-1:0]   rd_val_out,
  output logic              rd_valid_out,

  output logic              commit_valid,
  output logic              pipeline_flush,
  output logic [XLEN-1:0]   pipeline_pc,
  output logic [CNT_W-1:0]  retired_count,

  output logic [11:0]       axil_csr_awaddr,
  output logic              axil_csr_awvalid,
  input  logic              axil_csr_awready,
  output logic [XLEN-1:0]   axil_csr_wdata,
  output logic              axil_csr_wvalid,
  input  logic              axil_csr_wready,
  input  logic [1:0]        axil_csr_bresp,
  input  logic              axil_csr_bvalid,
  output logic              axil_csr_bready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_Q = PTR_W + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] jump_pc;
    logic            jump_valid;
    logic [5:0]      exc_num;
    logic [XLEN-1:0] exc_val;
    logic            exc_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_val;
    logic [1:0]      st_size;
    logic            st_valid;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_val;
    logic            csr_valid;
  } entry_t;

  typedef enum logic [2:0] {
    HC_EMPTY,
    HC_EXCEPTION,
    HC_WAIT_FIFO,
    HC_CSR,
    HC_COMMIT
  } head_class_t;

  typedef enum logic [1:0] {
    CSR_IDLE,
    CSR_ADDR_DATA,
    CSR_BRESP,
    CSR_DONE
  } csr_state_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_Q-1:0]   r_count;
  logic [CNT_W-1:0]   r_retired;

  csr_state_t         r_state, w_state_next;
  logic               r_aw_done, w_aw_done_next;
  logic               r_w_done, w_w_done_next;
  logic               r_err, w_err_next;

  entry_t             w_in;
  entry_t             w_head;
  head_class_t        w_class;
  logic               w_push;
  logic               w_pop;

  assign w_in = '{
    rd:         execute_rd,
    rd_val:     execute_rd_val,
    inst_pc:    execute_inst_pc,
    jump_pc:    execute_jump_pc,
    jump_valid: execute_jump_valid,
    exc_num:    execute_exception_num,
    exc_val:    execute_exception_val,
    exc_valid:  execute_exception_valid,
    st_addr:    execute_store_addr,
    st_val:     execute_store_val,
    st_size:    execute_store_size,
    st_valid:   execute_store_valid,
    csr_addr:   execute_csr_write_addr,
    csr_val:    execute_csr_write_val,
    csr_valid:  execute_csr_write_valid
  };

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    if (r_count == '0)
      w_class = HC_EMPTY;
    else if (w_head.exc_valid)
      w_class = HC_EXCEPTION;
    else if (w_head.st_valid && datafifo_full)
      w_class = HC_WAIT_FIFO;
    else if (w_head.csr_valid)
      w_class = HC_CSR;
    else
      w_class = HC_COMMIT;
  end

  // No pop-through: a full queue stays closed even while the head retires.
  assign execute_ready = (r_count < CNT_Q'(DEPTH)) && !pipeline_flush;
  assign w_push        = execute_valid && execute_ready;
  assign w_pop         = commit_valid;
  assign retired_count = r_retired;

  always_comb begin
    datafifo_addr_out   = '0;
    datafifo_val_out    = '0;
    datafifo_size_out   = '0;
    datafifo_valid_out  = 1'b0;
    exception_num_out   = '0;
    exception_val_out   = '0;
    exception_pc_out    = '0;
    exception_valid_out = 1'b0;
    rd_out              = '0;
    rd_val_out          = '0;
    rd_valid_out        = 1'b0;
    commit_valid        = 1'b0;
    pipeline_flush      = 1'b0;
    pipeline_pc         = '0;
    axil_csr_awaddr     = '0;
    axil_csr_awvalid    = 1'b0;
    axil_csr_wdata      = '0;
    axil_csr_wvalid     = 1'b0;
    axil_csr_bready     = 1'b0;
    w_state_next        = r_state;
    w_aw_done_next      = r_aw_done;
    w_w_done_next       = r_w_done;
    w_err_next          = r_err;

    case (r_state)
      CSR_IDLE: begin
        case (w_class)
          HC_COMMIT: begin
            commit_valid       = 1'b1;
            rd_valid_out       = (w_head.rd != '0);
            rd_out             = rd_valid_out ? w_head.rd : '0;
            rd_val_out         = rd_valid_out ? w_head.rd_val : '0;
            datafifo_valid_out = w_head.st_valid;
            datafifo_addr_out  = w_head.st_valid ? w_head.st_addr : '0;
            datafifo_val_out   = w_head.st_valid ? w_head.st_val : '0;
            datafifo_size_out  = w_head.st_valid ? w_head.st_size : '0;
            pipeline_flush     = w_head.jump_valid;
            pipeline_pc        = w_head.jump_pc;
          end
          HC_EXCEPTION: begin
            commit_valid        = 1'b1;
            exception_valid_out = 1'b1;
            exception_num_out   = w_head.exc_num;
            exception_val_out   = w_head.exc_val;
            exception_pc_out    = w_head.inst_pc;
            pipeline_flush      = 1'b1;
            pipeline_pc         = w_head.jump_pc;
          end
          HC_CSR: begin
            w_state_next   = CSR_ADDR_DATA;
            w_aw_done_next = 1'b0;
            w_w_done_next  = 1'b0;
          end
          default: ;
        endcase
      end

      CSR_ADDR_DATA: begin
        // AW and W are independent channels; each drops after its own handshake.
        axil_csr_awvalid = !r_aw_done;
        axil_csr_wvalid  = !r_w_done;
        axil_csr_awaddr  = w_head.csr_addr;
        axil_csr_wdata   = w_head.csr_val;
        w_aw_done_next   = r_aw_done || axil_csr_awready;
        w_w_done_next    = r_w_done || axil_csr_wready;
        if (w_aw_done_next && w_w_done_next)
          w_state_next = CSR_BRESP;
      end

      CSR_BRESP: begin
        axil_csr_bready = 1'b1;
        if (axil_csr_bvalid) begin
          w_err_next   = (axil_csr_bresp != 2'b00);
          w_state_next = CSR_DONE;
        end
      end

      CSR_DONE: begin
        commit_valid = 1'b1;
        pipeline_pc  = w_head.jump_pc;
        if (r_err) begin
          exception_valid_out = 1'b1;
          exception_num_out   = 6'(CSR_EXC_NUM);
          exception_val_out   = XLEN'(w_head.csr_addr);
          exception_pc_out    = w_head.inst_pc;
          pipeline_flush      = 1'b1;
        end else begin
          rd_valid_out   = (w_head.rd != '0);
          rd_out         = rd_valid_out ? w_head.rd : '0;
          rd_val_out     = rd_valid_out ? w_head.rd_val : '0;
          pipeline_flush = w_head.jump_valid;
        end
        w_state_next = CSR_IDLE;
      end

      default: w_state_next = CSR_IDLE;
    endcase
  end

  // Payload storage has no reset; only pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (pipeline_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_Q'(w_push) - CNT_Q'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= CSR_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_aw_done <= w_aw_done_next;
      r_w_done  <= w_w_done_next;
      r_err     <= w_err_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_retired <= '0;
    else if (commit_valid && !exception_valid_out)
      r_retired <= r_retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_commit_queue.sv
// Directed bench for commit_queue: a table of single-entry retirements plus
// hand-written sequences for throughput, backpressure, flush, CSR writes and async reset.
module tb_commit_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        execute_valid, execute_ready;
  logic [4:0]  execute_rd;
  logic [31:0] execute_rd_val, execute_inst_pc, execute_jump_pc;
  logic        execute_jump_valid;
  logic [5:0]  execute_exception_num;
  logic [31:0] execute_exception_val;
  logic        execute_exception_valid;
  logic [31:0] execute_store_addr, execute_store_val;
  logic [1:0]  execute_store_size;
  logic        execute_store_valid;
  logic [11:0] execute_csr_write_addr;
  logic [31:0] execute_csr_write_val;
  logic        execute_csr_write_valid;
  logic        datafifo_full;
  logic [31:0] datafifo_addr_out, datafifo_val_out;
  logic [1:0]  datafifo_size_out;
  logic        datafifo_valid_out;
  logic [5:0]  exception_num_out;
  logic [31:0] exception_val_out, exception_pc_out;
  logic        exception_valid_out;
  logic [4:0]  rd_out;
  logic [31:0] rd_val_out;
  logic        rd_valid_out;
  logic        commit_valid, pipeline_flush;
  logic [31:0] pipeline_pc;
  logic [63:0] retired_count;
  logic [11:0] axil_csr_awaddr;
  logic        axil_csr_awvalid, axil_csr_awready;
  logic [31:0] axil_csr_wdata;
  logic        axil_csr_wvalid, axil_csr_wready;
  logic [1:0]  axil_csr_bresp;
  logic        axil_csr_bvalid, axil_csr_bready;

  commit_queue #(.XLEN(32), .DEPTH(4), .CSR_EXC_NUM(2), .CNT_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .execute_valid(execute_valid), .execute_ready(execute_ready),
    .execute_rd(execute_rd), .execute_rd_val(execute_rd_val),
    .execute_inst_pc(execute_inst_pc), .execute_jump_pc(execute_jump_pc),
    .execute_jump_valid(execute_jump_valid),
    .execute_exception_num(execute_exception_num), .execute_exception_val(execute_exception_val),
    .execute_exception_valid(execute_exception_valid),
    .execute_store_addr(execute_store_addr), .execute_store_val(execute_store_val),
    .execute_store_size(execute_store_size), .execute_store_valid(execute_store_valid),
    .execute_csr_write_addr(execute_csr_write_addr), .execute_csr_write_val(execute_csr_write_val),
    .execute_csr_write_valid(execute_csr_write_valid),
    .datafifo_full(datafifo_full),
    .datafifo_addr_out(datafifo_addr_out), .datafifo_val_out(datafifo_val_out),
    .datafifo_size_out(datafifo_size_out), .datafifo_valid_out(datafifo_valid_out),
    .exception_num_out(exception_num_out), .exception_val_out(exception_val_out),
    .exception_pc_out(exception_pc_out), .exception_valid_out(exception_valid_out),
    .rd_out(rd_out), .rd_val_out(rd_val_out), .rd_valid_out(rd_valid_out),
    .commit_valid(commit_valid), .pipeline_flush(pipeline_flush), .pipeline_pc(pipeline_pc),
    .retired_count(retired_count),
    .axil_csr_awaddr(axil_csr_awaddr), .axil_csr_awvalid(axil_csr_awvalid),
    .axil_csr_awready(axil_csr_awready),
    .axil_csr_wdata(axil_csr_wdata), .axil_csr_wvalid(axil_csr_wvalid),
    .axil_csr_wready(axil_csr_wready),
    .axil_csr_bresp(axil_csr_bresp), .axil_csr_bvalid(axil_csr_bvalid),
    .axil_csr_bready(axil_csr_bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rd_val, inst_pc, jump_pc;
    logic        jv;
    logic        exv;
    logic [5:0]  en;
    logic [31:0] ev;
    logic        stv;
    logic [31:0] sa, sv;
    logic [1:0]  ss;
    logic        cvld;
    logic [11:0] ca;
    logic [31:0] cv;
  } ent_t;

  typedef struct {
    ent_t e;
    logic full;
    logic x_commit, x_rdv, x_dfv, x_excv, x_flush;
    int   inc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_ret = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ent_t mk(input logic [4:0] rd, input logic [31:0] rv, input logic [31:0] pc,
                              input logic [31:0] jpc, input logic jv, input logic exv,
                              input logic [5:0] en, input logic [31:0] ev, input logic stv,
                              input logic [31:0] sa, input logic [31:0] sv, input logic [1:0] ss,
                              input logic cvld, input logic [11:0] ca, input logic [31:0] cv);
    ent_t e;
    e.rd = rd; e.rd_val = rv; e.inst_pc = pc; e.jump_pc = jpc; e.jv = jv;
    e.exv = exv; e.en = en; e.ev = ev;
    e.stv = stv; e.sa = sa; e.sv = sv; e.ss = ss;
    e.cvld = cvld; e.ca = ca; e.cv = cv;
    return e;
  endfunction

  task automatic apply(input ent_t e);
    execute_rd = e.rd; execute_rd_val = e.rd_val;
    execute_inst_pc = e.inst_pc; execute_jump_pc = e.jump_pc; execute_jump_valid = e.jv;
    execute_exception_valid = e.exv; execute_exception_num = e.en; execute_exception_val = e.ev;
    execute_store_valid = e.stv; execute_store_addr = e.sa;
    execute_store_val = e.sv; execute_store_size = e.ss;
    execute_csr_write_valid = e.cvld; execute_csr_write_addr = e.ca; execute_csr_write_val = e.cv;
  endtask

  function automatic ent_t alu(input logic [4:0] rd, input logic [31:0] rv);
    return mk(rd, rv, 32'h0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0,
              1'b0, 12'h0, 32'h0);
  endfunction

  function automatic ent_t csr_ent(input logic [31:0] pc, input logic [31:0] jpc);
    return mk(5'd3, 32'h77, pc, jpc, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0,
              1'b1, 12'h300, 32'hA5);
  endfunction

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    execute_valid = 1'b0;
    apply(alu(5'd0, 32'h0));
    datafifo_full = 1'b0;
    axil_csr_awready = 1'b0; axil_csr_wready = 1'b0;
    axil_csr_bvalid = 1'b0; axil_csr_bresp = 2'b00;

    vecs[0] = '{e: mk(5'd7, 32'h1234, 32'h10, 32'h0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 32'h0),
                full: 0, x_commit: 1, x_rdv: 1, x_dfv: 0, x_excv: 0, x_flush: 0, inc: 1};
    vecs[1] = '{e: mk(5'd0, 32'h55, 32'h14, 32'h0, 0, 0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 32'h0),
                full: 0, x_commit: 1, x_rdv: 0, x_dfv: 0, x_excv: 0, x_flush: 0, inc: 1};
    vecs[2] = '{e: mk(5'd0, 32'h0, 32'h18, 32'h0, 0, 0, 6'd0, 32'h0, 1, 32'h2000, 32'hdead, 2'd2, 0, 12'h0, 32'h0),
                full: 0, x_commit: 1, x_rdv: 0, x_dfv: 1, x_excv: 0, x_flush: 0, inc: 1};
    vecs[3] = '{e: mk(5'd2, 32'h22, 32'h1c, 32'h0, 0, 0, 6'd0, 32'h0, 1, 32'h2004, 32'hbeef, 2'd1, 0, 12'h0, 32'h0),
                full: 1, x_commit: 0, x_rdv: 0, x_dfv: 0, x_excv: 0, x_flush: 0, inc: 1};
    vecs[4] = '{e: mk(5'd3, 32'h33, 32'h40, 32'h80, 0, 1, 6'd5, 32'hbad, 1, 32'h2008, 32'h1, 2'd0, 0, 12'h0, 32'h0),
                full: 0, x_commit: 1, x_rdv: 0, x_dfv: 0, x_excv: 1, x_flush: 1, inc: 0};
    vecs[5] = '{e: mk(5'd2, 32'h66, 32'h44, 32'h300, 1, 0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 32'h0),
                full: 0, x_commit: 1, x_rdv: 1, x_dfv: 0, x_excv: 0, x_flush: 1, inc: 1};
    vecs[6] = '{e: mk(5'd0, 32'h0, 32'h48, 32'h90, 0, 1, 6'd9, 32'h77, 1, 32'h200c, 32'h0, 2'd0, 0, 12'h0, 32'h0),
                full: 1, x_commit: 1, x_rdv: 0, x_dfv: 0, x_excv: 1, x_flush: 1, inc: 0};
    vecs[7] = '{e: mk(5'd1, 32'h11, 32'h4c, 32'h123, 0, 0, 6'd0, 32'h0, 0, 32'h0, 32'h0, 2'd0, 0, 12'h0, 32'h0),
                full: 0, x_commit: 1, x_rdv: 1, x_dfv: 0, x_excv: 0, x_flush: 0, inc: 1};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", execute_ready, 1);
    chk("rst_commit", commit_valid, 0);
    chk("rst_flush", pipeline_flush, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_awvalid", axil_csr_awvalid, 0);
    chk("rst_wvalid", axil_csr_wvalid, 0);
    chk("rst_bready", axil_csr_bready, 0);
    chk("rst_rdv", rd_valid_out, 0);
    $display("reset: ready=%0b commit=%0b retired=%0d", execute_ready, commit_valid, retired_count);
    @(negedge clk);
    reset_n = 1'b1;

    // Table of single-entry retirements into an empty queue
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apply(vecs[i].e);
      datafifo_full = vecs[i].full;
      execute_valid = 1'b1;
      @(negedge clk);
      execute_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_commit", i), commit_valid, vecs[i].x_commit);
      chk($sformatf("v%0d_rdv", i), rd_valid_out, vecs[i].x_rdv);
      chk($sformatf("v%0d_dfv", i), datafifo_valid_out, vecs[i].x_dfv);
      chk($sformatf("v%0d_excv", i), exception_valid_out, vecs[i].x_excv);
      chk($sformatf("v%0d_flush", i), pipeline_flush, vecs[i].x_flush);
      chk($sformatf("v%0d_ready", i), execute_ready, !vecs[i].x_flush);
      if (vecs[i].x_rdv) begin
        chk($sformatf("v%0d_rd", i), rd_out, vecs[i].e.rd);
        chk($sformatf("v%0d_rdval", i), rd_val_out, vecs[i].e.rd_val);
      end
      if (vecs[i].x_dfv) begin
        chk($sformatf("v%0d_staddr", i), datafifo_addr_out, vecs[i].e.sa);
        chk($sformatf("v%0d_stval", i), datafifo_val_out, vecs[i].e.sv);
        chk($sformatf("v%0d_stsize", i), datafifo_size_out, vecs[i].e.ss);
      end
      if (vecs[i].x_excv) begin
        chk($sformatf("v%0d_excnum", i), exception_num_out, vecs[i].e.en);
        chk($sformatf("v%0d_excval", i), exception_val_out, vecs[i].e.ev);
        chk($sformatf("v%0d_excpc", i), exception_pc_out, vecs[i].e.inst_pc);
      end
      if (vecs[i].x_commit)
        chk($sformatf("v%0d_pc", i), pipeline_pc, vecs[i].e.jump_pc);
      datafifo_full = 1'b0;
      @(negedge clk);
      #1;
      exp_ret = exp_ret + 64'(vecs[i].inc);
      chk($sformatf("v%0d_retired", i), retired_count, exp_ret);
      chk($sformatf("v%0d_drained", i), commit_valid, 0);
      $display("vec %0d: commit=%0b rdv=%0b dfv=%0b exc=%0b flush=%0b retired=%0d",
               i, vecs[i].x_commit, vecs[i].x_rdv, vecs[i].x_dfv, vecs[i].x_excv,
               vecs[i].x_flush, retired_count);
    end

    // Throughput: 8 back-to-back ALU entries
    @(negedge clk);
    apply(alu(5'd1, 32'h10));
    execute_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("tp%0d_commit", i), commit_valid, 1);
      chk($sformatf("tp%0d_rd", i), rd_out, 64'(i));
      chk($sformatf("tp%0d_rdval", i), rd_val_out, 64'(32'h10 * i));
      if (i < 8) apply(alu(5'(i + 1), 32'(32'h10 * (i + 1))));
      else execute_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    exp_ret = exp_ret + 8;
    chk("tp_idle", commit_valid, 0);
    chk("tp_retired", retired_count, exp_ret);
    $display("throughput: retired=%0d", retired_count);

    // Backpressure: 5 stores against a full data FIFO
    datafifo_full = 1'b1;
    apply(mk(5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 6'd0, 32'h0, 1, 32'h1000, 32'h0, 2'd2, 0, 12'h0, 32'h0));
    execute_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(mk(5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 6'd0, 32'h0, 1, 32'(32'h1000 + 32'h10 * (i + 1)),
               32'(i + 1), 2'd2, 0, 12'h0, 32'h0));
    end
    #1;
    chk("bp_ready_full", execute_ready, 0);
    chk("bp_hold_dfv", datafifo_valid_out, 0);
    chk("bp_hold_commit", commit_valid, 0);
    datafifo_full = 1'b0;
    #1;
    chk("bp_rel_dfv", datafifo_valid_out, 1);
    chk("bp_rel_addr", datafifo_addr_out, 32'h1000);
    chk("bp_rel_ready", execute_ready, 0);
    @(negedge clk);
    datafifo_full = 1'b1;
    #1;
    chk("bp_ready_after", execute_ready, 1);
    @(negedge clk);
    execute_valid = 1'b0;
    #1;
    chk("bp_fifth_full", execute_ready, 0);
    chk("bp_fifth_dfv", datafifo_valid_out, 0);
    datafifo_full = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("bp_drain%0d_dfv", k), datafifo_valid_out, 1);
      chk($sformatf("bp_drain%0d_addr", k), datafifo_addr_out, 64'(32'h1000 + 32'h10 * k));
      @(negedge clk);
    end
    #1;
    exp_ret = exp_ret + 5;
    chk("bp_idle", commit_valid, 0);
    chk("bp_retired", retired_count, exp_ret);
    $display("backpressure: retired=%0d", retired_count);

    // Jump flush with younger entries queued behind the head
    datafifo_full = 1'b1;
    apply(mk(5'd4, 32'h44, 32'h100, 32'h200, 1, 0, 6'd0, 32'h0, 1, 32'h3000, 32'h9, 2'd2, 0, 12'h0, 32'h0));
    execute_valid = 1'b1;
    @(negedge clk);
    apply(alu(5'd5, 32'h55));
    @(negedge clk);
    apply(alu(5'd6, 32'h66));
    @(negedge clk);
    execute_valid = 1'b0;
    #1;
    chk("jf_wait_commit", commit_valid, 0);
    datafifo_full = 1'b0;
    #1;
    chk("jf_flush", pipeline_flush, 1);
    chk("jf_pc", pipeline_pc, 32'h200);
    chk("jf_commit", commit_valid, 1);
    chk("jf_ready_low", execute_ready, 0);
    chk("jf_rd", rd_out, 4);
    @(negedge clk);
    #1;
    chk("jf_cleared_commit", commit_valid, 0);
    chk("jf_cleared_rdv", rd_valid_out, 0);
    chk("jf_cleared_ready", execute_ready, 1);
    @(negedge clk);
    #1;
    chk("jf_young_rdv", rd_valid_out, 0);
    exp_ret = exp_ret + 1;
    chk("jf_retired", retired_count, exp_ret);
    $display("jump flush: pc=200 retired=%0d", retired_count);

    // CSR write OK, awready two cycles after wready
    apply(csr_ent(32'h500, 32'h504));
    execute_valid = 1'b1;
    @(negedge clk);
    execute_valid = 1'b0;
    #1;
    chk("csr_idle_aw", axil_csr_awvalid, 0);
    chk("csr_idle_commit", commit_valid, 0);
    @(negedge clk);
    #1;
    chk("csr_awvalid", axil_csr_awvalid, 1);
    chk("csr_wvalid", axil_csr_wvalid, 1);
    chk("csr_awaddr", axil_csr_awaddr, 12'h300);
    chk("csr_wdata", axil_csr_wdata, 32'hA5);
    axil_csr_wready = 1'b1;
    @(negedge clk);
    axil_csr_wready = 1'b0;
    #1;
    chk("csr_w_dropped", axil_csr_wvalid, 0);
    chk("csr_aw_held", axil_csr_awvalid, 1);
    @(negedge clk);
    #1;
    chk("csr_aw_held2", axil_csr_awvalid, 1);
    axil_csr_awready = 1'b1;
    @(negedge clk);
    axil_csr_awready = 1'b0;
    #1;
    chk("csr_aw_dropped", axil_csr_awvalid, 0);
    chk("csr_bready", axil_csr_bready, 1);
    chk("csr_b_commit", commit_valid, 0);
    axil_csr_bvalid = 1'b1; axil_csr_bresp = 2'b00;
    @(negedge clk);
    axil_csr_bvalid = 1'b0;
    #1;
    chk("csr_done_commit", commit_valid, 1);
    chk("csr_done_rdv", rd_valid_out, 1);
    chk("csr_done_rd", rd_out, 3);
    chk("csr_done_rdval", rd_val_out, 32'h77);
    chk("csr_done_exc", exception_valid_out, 0);
    chk("csr_done_flush", pipeline_flush, 0);
    @(negedge clk);
    #1;
    exp_ret = exp_ret + 1;
    chk("csr_single_done", commit_valid, 0);
    chk("csr_retired", retired_count, exp_ret);
    $display("csr ok: retired=%0d", retired_count);

    // CSR write error, both channels ready in the same cycle
    apply(csr_ent(32'h600, 32'h604));
    execute_valid = 1'b1;
    @(negedge clk);
    execute_valid = 1'b0;
    @(negedge clk);
    axil_csr_awready = 1'b1; axil_csr_wready = 1'b1;
    @(negedge clk);
    axil_csr_awready = 1'b0; axil_csr_wready = 1'b0;
    #1;
    chk("csre_bready", axil_csr_bready, 1);
    chk("csre_awvalid", axil_csr_awvalid, 0);
    chk("csre_wvalid", axil_csr_wvalid, 0);
    axil_csr_bvalid = 1'b1; axil_csr_bresp = 2'b10;
    @(negedge clk);
    axil_csr_bvalid = 1'b0; axil_csr_bresp = 2'b00;
    #1;
    chk("csre_commit", commit_valid, 1);
    chk("csre_exc", exception_valid_out, 1);
    chk("csre_num", exception_num_out, 2);
    chk("csre_val", exception_val_out, 32'h300);
    chk("csre_pc", exception_pc_out, 32'h600);
    chk("csre_flush", pipeline_flush, 1);
    chk("csre_flush_pc", pipeline_pc, 32'h604);
    chk("csre_rdv", rd_valid_out, 0);
    @(negedge clk);
    #1;
    chk("csre_retired", retired_count, exp_ret);
    $display("csr err: exc num=2 retired=%0d", retired_count);

    // Async reset mid-BRESP with two entries queued
    apply(csr_ent(32'h700, 32'h704));
    execute_valid = 1'b1;
    @(negedge clk);
    apply(alu(5'd9, 32'h99));
    @(negedge clk);
    execute_valid = 1'b0;
    axil_csr_awready = 1'b1; axil_csr_wready = 1'b1;
    @(negedge clk);
    axil_csr_awready = 1'b0; axil_csr_wready = 1'b0;
    #1;
    chk("ar_in_bresp", axil_csr_bready, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_bready", axil_csr_bready, 0);
    chk("ar_commit", commit_valid, 0);
    chk("ar_ready", execute_ready, 1);
    chk("ar_retired", retired_count, 0);
    chk("ar_awvalid", axil_csr_awvalid, 0);
    exp_ret = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_post_ready", execute_ready, 1);
    chk("ar_post_bready", axil_csr_bready, 0);
    chk("ar_post_awvalid", axil_csr_awvalid, 0);
    chk("ar_post_commit", commit_valid, 0);
    apply(alu(5'd10, 32'hA0));
    execute_valid = 1'b1;
    @(negedge clk);
    execute_valid = 1'b0;
    #1;
    chk("ar_post_push_commit", commit_valid, 1);
    chk("ar_post_push_rd", rd_out, 10);
    @(negedge clk);
    #1;
    exp_ret = exp_ret + 1;
    chk("ar_post_retired", retired_count, exp_ret);
    $display("async reset: ready=%0b retired=%0d", execute_ready, retired_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Parametrised successor to the single-entry commit stage.
- Holds up to DEPTH executed instructions in an in-order circular queue and retires the head entry each cycle. A retirement may be a register writeback, a data-FIFO store, an exception, a jump flush, or a CSR write over AXI-Lite.
- Sits between execute and the regfile, data FIFO and CSR block. Replaces the execute stall with a ready handshake.
- Adds overlapped AW/W CSR writes, BRESP error detection and a retired-instruction counter.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, queue entries; power of two, >=2
CSR_EXC_NUM, 2, exception number raised on a CSR write error
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
reset_n  in  1  reset
execute_valid  in  1  execute presents an entry
execute_ready  out  1  queue can accept an entry
execute_rd / execute_rd_val  in  5 / XLEN  destination register and value
execute_inst_pc / execute_jump_pc / execute_jump_valid  in  XLEN / XLEN / 1  instruction PC, jump target, jump flag
execute_exception_num / _val / _valid  in  6 / XLEN / 1  exception from execute
execute_store_addr / _val / _size / _valid  in  XLEN / XLEN / 2 / 1  store request
execute_csr_write_addr / _val / _valid  in  12 / XLEN / 1  CSR write request
datafifo_full  in  1  data FIFO cannot accept
datafifo_addr_out / _val_out / _size_out / _valid_out  out  XLEN / XLEN / 2 / 1  store to data FIFO
exception_num_out / _val_out / _pc_out / _valid_out  out  6 / XLEN / XLEN / 1  exception report
rd_out / rd_val_out / rd_valid_out  out  5 / XLEN / 1  register writeback
commit_valid  out  1  head entry retired this cycle
pipeline_flush / pipeline_pc  out  1 / XLEN  flush request and redirect PC
retired_count  out  CNT_W  count of instructions retired without exception
axil_csr_awaddr/awvalid/awready, wdata/wvalid/wready, bresp/bvalid/bready  mixed  12,1,1,XLEN,1,1,2,1,1  AXI-Lite CSR write master

Behaviour:
- Reset and clock: one clock. Reset is asynchronous and active-low. Port names are clk and reset_n.
- Reset state:
  - queue empty (count=0); CSR FSM in IDLE; retired_count=0.
  - every output 0, except execute_ready=1.
  - reset mid-CSR-transaction abandons it; the AXI slave must also be reset.
- Enqueue:
  - push when execute_valid && execute_ready.
  - execute_ready = (count<DEPTH) && !pipeline_flush.
  - no pop-through: when full, ready stays low even if the head retires this cycle.
- Latency: an entry pushed in cycle N is at the head in N+1 at the earliest. There is no bypass.
- Head classification, first match wins:
  - EMPTY when count==0.
  - EXCEPTION when exception_valid.
  - WAIT_FIFO when store_valid && datafifo_full.
  - CSR when csr_write_valid.
  - otherwise COMMIT.
- COMMIT (one cycle):
  - commit_valid=1; rd_valid_out = (rd!=0); datafifo_valid_out = store_valid.
  - pipeline_flush = jump_valid; pipeline_pc = jump_pc.
  - pop the head.
- EXCEPTION (one cycle):
  - exception_valid_out=1 with the entry's num, val and pc.
  - commit_valid=1; pipeline_flush=1; pipeline_pc=jump_pc; no rd or store.
- WAIT_FIFO: hold the entry with no outputs asserted until datafifo_full=0.
- Flush: whenever pipeline_flush=1, the whole queue is cleared at the clock edge (count<=0), including younger entries. execute_ready is low that cycle, so nothing is pushed.
- CSR FSM:
  - IDLE: when the head is CSR, go to ADDR_DATA.
  - ADDR_DATA: awvalid and wvalid assert together. Each deasserts independently after its own handshake. Go to BRESP when both have handshaken, including in the same cycle.
  - BRESP: bready=1. On bvalid, latch err=(bresp!=0) and go to DONE.
  - DONE: one cycle. commit_valid=1.
    - err=0: rd_valid_out=(rd!=0); flush if jump_valid.
    - err=1: exception_valid_out=1, num=CSR_EXC_NUM, val=csr_addr, pc=inst_pc; pipeline_flush=1, pipeline_pc=jump_pc.
    - pop the head and return to IDLE.
- retired_count: increments on commit_valid && !exception_valid_out. Wraps modulo 2^CNT_W.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.

Test Plan:
- Throughput: push 8 back-to-back ALU entries with rd=1..8 and val=0x10*i, DEPTH=4 -> 8 consecutive commit_valid cycles starting one cycle after the first push, rd_out in order 1..8, retired_count=8.
- Backpressure: push 5 stores with datafifo_full=1 -> execute_ready=0 after the 4th push. Release full for 1 cycle -> one store of addr 0x1000 emitted; 5th entry accepted the following cycle.
- Jump flush: 3 queued entries, head jump_valid with jump_pc=0x200 -> pipeline_flush=1, pipeline_pc=0x200, count=0 next cycle, younger rd never written.
- CSR write OK: addr 0x300, val 0xA5; awready arrives 2 cycles after wready, bresp=0 -> single DONE cycle, commit_valid=1, rd written, no exception.
- CSR write error: bresp=2 -> exception_valid_out=1, num=2, val=0x300, flush asserted, retired_count unchanged.
- Async reset: assert reset_n=0 mid-BRESP with 2 entries queued -> outputs 0 immediately without a clock; after release execute_ready=1 and the FSM is in IDLE.
